// File: rtl/execute_memory_register.sv
// EX/MEM pipeline register of the MIPS32 core; turns a signed-overflow from the ALU into a precise trap.
// Latency: 1 cycle, EX inputs to MEM outputs; every output is registered.
// Backpressure: stall holds all pipeline outputs and drops the exception pulse; flush loads a bubble and overrides stall.
//
// Ports:
//   clock, reset (sync, active-low), stall, flush       - pipeline control
//   ex_*                                                 - execute-stage instruction and control bits
//   mem_*                                                - registered copies for the memory stage
//   exception, epc, overflow_count                       - trap pulse, trapping PC, saturating trap counter
module execute_memory_register #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   ex_valid,
  input  logic [31:0]            ex_pc,
  input  logic [31:0]            ex_alu_result,
  input  logic                   ex_overflow,
  input  logic [31:0]            ex_store_data,
  input  logic [4:0]             ex_write_reg,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic                   ex_mem_to_reg,
  output logic                   mem_valid,
  output logic [31:0]            mem_alu_result,
  output logic [31:0]            mem_store_data,
  output logic [4:0]             mem_write_reg,
  output logic                   mem_reg_write,
  output logic                   mem_mem_read,
  output logic                   mem_mem_write,
  output logic                   mem_mem_to_reg,
  output logic                   exception,
  output logic [31:0]            epc,
  output logic [COUNT_WIDTH-1:0] overflow_count
);

  logic                   valid_q,     valid_d;
  logic [31:0]            alu_q,       alu_d;
  logic [31:0]            store_q,     store_d;
  logic [4:0]             wreg_q,      wreg_d;
  logic                   reg_write_q, reg_write_d;
  logic                   mem_read_q,  mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic                   mem_to_reg_q, mem_to_reg_d;
  logic                   exc_q,       exc_d;
  logic [31:0]            epc_q,       epc_d;
  logic [COUNT_WIDTH-1:0] cnt_q,       cnt_d;

  logic trap;
  assign trap = ex_valid & ex_overflow;

  always_comb begin
    // Default: hold everything; the exception pulse never survives a cycle on its own.
    valid_d      = valid_q;
    alu_d        = alu_q;
    store_d      = store_q;
    wreg_d       = wreg_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    exc_d        = 1'b0;
    epc_d        = epc_q;
    cnt_d        = cnt_q;

    if (flush) begin
      valid_d      = 1'b0;
      alu_d        = '0;
      store_d      = '0;
      wreg_d       = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (stall) begin
      // hold: defaults already cover it
    end else if (trap) begin
      // Squash the faulting instruction but keep its wrapped result visible for debug.
      valid_d      = 1'b0;
      alu_d        = ex_alu_result;
      store_d      = ex_store_data;
      wreg_d       = ex_write_reg;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      exc_d        = 1'b1;
      epc_d        = ex_pc;
      if (cnt_q != {COUNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      valid_d      = ex_valid;
      alu_d        = ex_alu_result;
      store_d      = ex_store_data;
      wreg_d       = ex_write_reg;
      reg_write_d  = ex_reg_write  & ex_valid;
      mem_read_d   = ex_mem_read   & ex_valid;
      mem_write_d  = ex_mem_write  & ex_valid;
      mem_to_reg_d = ex_mem_to_reg & ex_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      store_q      <= '0;
      wreg_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      exc_q        <= 1'b0;
      epc_q        <= '0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_q        <= alu_d;
      store_q      <= store_d;
      wreg_q       <= wreg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      exc_q        <= exc_d;
      epc_q        <= epc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_q;
  assign mem_store_data = store_q;
  assign mem_write_reg  = wreg_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign exception      = exc_q;
  assign epc            = epc_q;
  assign overflow_count = cnt_q;

endmodule

// File: tb/tb_execute_memory_register.sv
module tb_execute_memory_register;

  logic        clock = 1'b0;
  logic        reset, stall, flush;
  logic        ex_valid, ex_overflow;
  logic [31:0] ex_pc, ex_alu_result, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_write_reg;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic        exception;
  logic [31:0] epc;
  logic [7:0]  overflow_count;

  execute_memory_register #(.COUNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
    .ex_overflow(ex_overflow), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_write_reg(mem_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .exception(exception), .epc(epc), .overflow_count(overflow_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: what the MEM side should show after the next edge.
  bit          m_valid, m_exc;
  bit [31:0]   m_alu, m_store, m_epc;
  bit [4:0]    m_wreg;
  bit [3:0]    m_ctrl;   // {reg_write, mem_read, mem_write, mem_to_reg}
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the instruction-level rules to the inputs present at this edge.
  task automatic model_edge();
    bit [3:0] ctrl;
    ctrl = {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    m_exc = 0;
    if (!reset) begin
      m_valid = 0; m_alu = 0; m_store = 0; m_wreg = 0; m_ctrl = 0;
      m_epc = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_alu = 0; m_store = 0; m_wreg = 0; m_ctrl = 0;
    end else if (stall) begin
      // pipeline frozen
    end else if (ex_valid && ex_overflow) begin
      m_valid = 0; m_ctrl = 0; m_alu = ex_alu_result;
      m_store = ex_store_data; m_wreg = ex_write_reg;
      m_exc = 1; m_epc = ex_pc;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end else begin
      m_valid = ex_valid; m_alu = ex_alu_result;
      m_store = ex_store_data; m_wreg = ex_write_reg;
      m_ctrl = ex_valid ? ctrl : 4'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(mem_valid), 32'(m_valid));
    chk({tag, ".alu"},   mem_alu_result, m_alu);
    chk({tag, ".store"}, mem_store_data, m_store);
    chk({tag, ".wreg"},  32'(mem_write_reg), 32'(m_wreg));
    chk({tag, ".ctrl"},  32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}), 32'(m_ctrl));
    chk({tag, ".exc"},   32'(exception), 32'(m_exc));
    chk({tag, ".epc"},   epc, m_epc);
    chk({tag, ".cnt"},   32'(overflow_count), m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_ex();
    ex_valid      = 1'($urandom_range(0, 1));
    ex_pc         = $urandom;
    ex_alu_result = $urandom;
    ex_overflow   = ($urandom_range(0, 3) == 0);
    ex_store_data = $urandom;
    ex_write_reg  = 5'($urandom);
    ex_reg_write  = 1'($urandom);
    ex_mem_read   = 1'($urandom);
    ex_mem_write  = 1'($urandom);
    ex_mem_to_reg = 1'($urandom);
  endtask

  task automatic set_ex(input bit v, input bit [31:0] pc, input bit [31:0] alu,
                        input bit ovf, input bit [31:0] sd, input bit [4:0] wr,
                        input bit [3:0] ctrl);
    ex_valid = v; ex_pc = pc; ex_alu_result = alu; ex_overflow = ovf;
    ex_store_data = sd; ex_write_reg = wr;
    {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = ctrl;
  endtask

  initial begin
    reset = 0; stall = 0; flush = 0;
    rand_ex();

    // Reset held for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      rand_ex(); stall = 1'($urandom); flush = 1'($urandom);
      step("reset");
    end
    chk("reset_valid", 32'(mem_valid), 0);
    chk("reset_cnt", 32'(overflow_count), 0);
    chk("reset_epc", epc, 0);

    // First valid ADD after reset release.
    reset = 1; stall = 0; flush = 0;
    set_ex(1, 32'h0040_0000, 32'h0000_0005, 0, 32'h0, 5'd8, 4'b1000);
    step("add");
    chk("add_valid", 32'(mem_valid), 1);
    chk("add_alu", mem_alu_result, 32'h0000_0005);
    chk("add_wreg", 32'(mem_write_reg), 8);
    chk("add_rw", 32'(mem_reg_write), 1);

    // Overflow trap.
    set_ex(1, 32'h0040_0010, 32'h8000_0000, 1, 32'h1234, 5'd9, 4'b1000);
    step("trap");
    chk("trap_exc", 32'(exception), 1);
    chk("trap_epc", epc, 32'h0040_0010);
    chk("trap_valid", 32'(mem_valid), 0);
    chk("trap_rw", 32'(mem_reg_write), 0);
    chk("trap_cnt", 32'(overflow_count), 1);
    chk("trap_alu", mem_alu_result, 32'h8000_0000);
    set_ex(1, 32'h0040_0014, 32'h7, 0, 32'h0, 5'd10, 4'b1000);
    step("after_trap");
    chk("after_trap_exc", 32'(exception), 0);
    chk("after_trap_epc", epc, 32'h0040_0010);

    // Stall holds a store.
    set_ex(1, 32'h0040_0018, 32'h1000_0040, 0, 32'hDEAD_BEEF, 5'd0, 4'b0010);
    step("sw");
    for (int i = 0; i < 3; i++) begin
      stall = 1; rand_ex();
      step("stall");
      chk("stall_sd", mem_store_data, 32'hDEAD_BEEF);
      chk("stall_mw", 32'(mem_mem_write), 1);
      chk("stall_alu", mem_alu_result, 32'h1000_0040);
    end
    stall = 0;
    set_ex(1, 32'h0040_001c, 32'h55, 0, 32'h66, 5'd3, 4'b1101);
    step("release");
    chk("release_alu", mem_alu_result, 32'h55);
    chk("release_mw", 32'(mem_mem_write), 0);

    // Flush beats stall beats trap.
    flush = 1; stall = 1;
    set_ex(1, 32'h0040_0020, 32'h8000_0001, 1, 32'h0, 5'd4, 4'b1000);
    step("flush_all");
    chk("flush_valid", 32'(mem_valid), 0);
    chk("flush_exc", 32'(exception), 0);
    chk("flush_cnt", 32'(overflow_count), 1);
    flush = 0; stall = 0;

    // Overflow on an invalid slot is ignored.
    set_ex(0, 32'h0040_0024, 32'h8000_0000, 1, 32'h0, 5'd5, 4'b1000);
    step("inv_ovf");
    chk("inv_ovf_exc", 32'(exception), 0);
    chk("inv_ovf_valid", 32'(mem_valid), 0);
    chk("inv_ovf_cnt", 32'(overflow_count), 1);

    // Trap followed by stall: single-cycle pulse, bubble kept.
    set_ex(1, 32'h0040_0028, 32'h8000_0000, 1, 32'h0, 5'd6, 4'b1000);
    step("trap2");
    chk("trap2_exc", 32'(exception), 1);
    stall = 1; rand_ex();
    step("trap2_stall");
    chk("trap2_stall_exc", 32'(exception), 0);
    chk("trap2_stall_valid", 32'(mem_valid), 0);
    chk("trap2_stall_epc", epc, 32'h0040_0028);
    stall = 0;

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      rand_ex();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) != 0);
      step("rand");
    end
    reset = 1; stall = 0; flush = 0;

    // Saturation after 300 back-to-back traps.
    for (int i = 0; i < 300; i++) begin
      set_ex(1, 32'h0050_0000 + 32'(i * 4), $urandom, 1, $urandom, 5'($urandom), 4'b1000);
      step("sat");
    end
    chk("sat_cnt", 32'(overflow_count), 255);
    chk("sat_epc", epc, 32'h0050_0000 + 32'(299 * 4));

    // Reset in the exception cycle clears everything.
    set_ex(1, 32'h0060_0000, 32'h8000_0000, 1, 32'h0, 5'd7, 4'b1000);
    reset = 0;
    step("reset_mid");
    chk("reset_mid_cnt", 32'(overflow_count), 0);
    chk("reset_mid_exc", 32'(exception), 0);
    chk("reset_mid_epc", epc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
